// File: rtl/approx_mult_error_sweeper_if.sv
// Sweeper <-> environment bundle: multiplier operand/product bus,
// start/busy/done handshake and the accumulated error statistics.
interface approx_mult_error_sweeper_if #(
  parameter int W     = 8,
  parameter int ACC_W = 48
);
  logic             start;
  logic [W-1:0]     mul_x;
  logic [W-1:0]     mul_y;
  logic [2*W-1:0]   mul_z;
  logic             busy;
  logic             done;
  logic [2*W:0]     err_cnt;
  logic [ACC_W-1:0] sum_err;
  logic [ACC_W-1:0] sum_sq_err;
  logic [2*W-1:0]   max_abs_err;

  modport master (
    input  start,
    input  mul_z,
    output mul_x,
    output mul_y,
    output busy,
    output done,
    output err_cnt,
    output sum_err,
    output sum_sq_err,
    output max_abs_err
  );

  modport slave (
    output start,
    output mul_z,
    input  mul_x,
    input  mul_y,
    input  busy,
    input  done,
    input  err_cnt,
    input  sum_err,
    input  sum_sq_err,
    input  max_abs_err
  );
endinterface

// File: rtl/approx_mult_error_sweeper.sv
// Exhaustive error sweep of an external combinational approximate
// multiplier: operand generation, exact compare and error accumulation.
module approx_mult_error_sweeper #(
  parameter int W     = 8,
  parameter int ACC_W = 48
) (
  input  logic clk,
  input  logic rst_n,
  approx_mult_error_sweeper_if.master bus
);
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PW-1:0]    cnt;
  logic [W-1:0]     x_q;
  logic [W-1:0]     y_q;
  logic             pv;
  logic             s1v;
  logic [W-1:0]     s1_x;
  logic [W-1:0]     s1_y;
  logic [PW-1:0]    s1_z;
  logic             done_q;

  logic [PW:0]      err_cnt_q;
  logic [ACC_W-1:0] sum_err_q;
  logic [ACC_W-1:0] sum_sq_q;
  logic [PW-1:0]    max_q;

  logic             accept;
  logic             last_pair;
  logic             last_acc;
  logic [PW-1:0]    prod;
  logic [PW:0]      e;
  logic [PW-1:0]    abs_e;
  logic [2*PW-1:0]  sq_e;

  assign accept    = ((state == IDLE) || (state == DONE)) && bus.start;
  assign last_pair = (cnt == {PW{1'b1}});
  assign last_acc  = s1v && !pv;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.start) state_nx = SWEEP;
      SWEEP: if (last_pair) state_nx = DRAIN;
      DRAIN: if (last_acc)  state_nx = DONE;
      DONE:  if (bus.start) state_nx = SWEEP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // pv tags the pair on mul_x/mul_y, s1v the pair held in stage 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      pv     <= 1'b0;
      s1v    <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_z   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == DRAIN) && last_acc;
      s1v    <= pv && !accept;
      s1_x   <= x_q;
      s1_y   <= y_q;
      s1_z   <= bus.mul_z;
      if (state == SWEEP) begin
        {x_q, y_q} <= cnt;
        cnt        <= cnt + PW'(1);
        pv         <= 1'b1;
      end else begin
        x_q <= '0;
        y_q <= '0;
        cnt <= '0;
        pv  <= 1'b0;
      end
    end
  end

  assign prod = {{W{1'b0}}, s1_x} * {{W{1'b0}}, s1_y};
  assign e    = {1'b0, s1_z} - {1'b0, prod};

  // Magnitude taken from the operands directly so no bit is left dangling
  assign abs_e = e[PW] ? (prod - s1_z) : (s1_z - prod);
  assign sq_e  = {{PW{1'b0}}, abs_e} * {{PW{1'b0}}, abs_e};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      sum_err_q <= '0;
      sum_sq_q  <= '0;
      max_q     <= '0;
    end else if (accept) begin
      err_cnt_q <= '0;
      sum_err_q <= '0;
      sum_sq_q  <= '0;
      max_q     <= '0;
    end else if (s1v) begin
      err_cnt_q <= err_cnt_q + {{PW{1'b0}}, |e};
      sum_err_q <= sum_err_q + {{(ACC_W-PW-1){e[PW]}}, e};
      sum_sq_q  <= sum_sq_q + {{(ACC_W-2*PW){1'b0}}, sq_e};
      if (abs_e > max_q) max_q <= abs_e;
    end
  end

  assign bus.mul_x       = x_q;
  assign bus.mul_y       = y_q;
  assign bus.busy        = pv | s1v;
  assign bus.done        = done_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.sum_err     = sum_err_q;
  assign bus.sum_sq_err  = sum_sq_q;
  assign bus.max_abs_err = max_q;
endmodule

// File: tb/tb_approx_mult_error_sweeper.sv
// Directed bench for the error sweeper at W=4 (256 pairs) driving a
// stub multiplier whose behaviour is selected per test.
module tb_approx_mult_error_sweeper;
  localparam int W     = 4;
  localparam int ACC_W = 48;
  localparam int N     = 256;
  localparam int LAT   = N + 2;

  // z = x*y+31 mod 256: e=+31 on 255 pairs, e=-225 on (15,15)
  localparam logic [8:0]  O_CNT = 9'd256;
  localparam logic [47:0] O_SUM = 48'd7680;
  localparam logic [47:0] O_SQ  = 48'd295680;
  localparam logic [7:0]  O_MAX = 8'd225;
  // z = 0: 225 nonzero products, sum x*y = 120^2, sum (x*y)^2 = 1240^2
  localparam logic [8:0]  Z_CNT = 9'd225;
  localparam logic [47:0] Z_SUM = 48'hFFFF_FFFF_C7C0;
  localparam logic [47:0] Z_SQ  = 48'd1537600;
  localparam logic [7:0]  Z_MAX = 8'd225;

  logic clk;
  logic rst_n;
  int   mode;
  int   n_chk;
  int   n_pass;
  logic [7:0] p;

  approx_mult_error_sweeper_if #(.W(W), .ACC_W(ACC_W)) bus ();

  approx_mult_error_sweeper #(.W(W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    p = {4'b0, bus.mul_x} * {4'b0, bus.mul_y};
    bus.mul_z = 8'd0;
    if (mode == 0)      bus.mul_z = p;
    else if (mode == 1) bus.mul_z = p + 8'd31;
  end

  task automatic sweep(input int glitch_at, output int lat);
    logic [7:0] exp_xy;
    logic       exp_busy;
    lat = -1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_chk++;
    if (bus.err_cnt !== 0 || bus.sum_sq_err !== 0 || bus.max_abs_err !== 0 || bus.busy !== 1'b0)
      $display("FAIL clear_on_start: cnt=%0d sq=%0d max=%0d busy=%b want 0",
               bus.err_cnt, bus.sum_sq_err, bus.max_abs_err, bus.busy);
    else n_pass++;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(posedge clk); #1;
      bus.start = (glitch_at > 0) && (k >= glitch_at) && (k < glitch_at + 5);
      exp_xy   = (k <= N) ? 8'(k - 1) : 8'd0;
      exp_busy = (k <= N + 1);
      n_chk++;
      if ({bus.mul_x, bus.mul_y} !== exp_xy)
        $display("FAIL operand_order k=%0d: got %0d,%0d want %0d,%0d",
                 k, bus.mul_x, bus.mul_y, exp_xy[7:4], exp_xy[3:0]);
      else n_pass++;
      n_chk++;
      if (bus.busy !== exp_busy)
        $display("FAIL busy k=%0d: got %b want %b", k, bus.busy, exp_busy);
      else n_pass++;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    n_chk++;
    if (lat !== LAT) $display("FAIL latency: got %0d want %0d", lat, LAT);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0;
    mode = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_chk++;
    if ({bus.mul_x, bus.mul_y, bus.busy, bus.done} !== 10'd0)
      $display("FAIL reset_ctrl: x=%0d y=%0d busy=%b done=%b want 0",
               bus.mul_x, bus.mul_y, bus.busy, bus.done);
    else n_pass++;
    n_chk++;
    if ({bus.err_cnt, bus.sum_err, bus.sum_sq_err, bus.max_abs_err} !== '0)
      $display("FAIL reset_results: cnt=%0d sum=%0d sq=%0d max=%0d want 0",
               bus.err_cnt, bus.sum_err, bus.sum_sq_err, bus.max_abs_err);
    else n_pass++;
  endtask

  task automatic test_exact;
    int lat;
    mode = 0;
    sweep(0, lat);
    n_chk++;
    if (bus.err_cnt !== 0) $display("FAIL exact_cnt: got %0d want 0", bus.err_cnt);
    else n_pass++;
    n_chk++;
    if (bus.sum_err !== 0) $display("FAIL exact_sum: got %0d want 0", bus.sum_err);
    else n_pass++;
    n_chk++;
    if (bus.sum_sq_err !== 0) $display("FAIL exact_sq: got %0d want 0", bus.sum_sq_err);
    else n_pass++;
    n_chk++;
    if (bus.max_abs_err !== 0) $display("FAIL exact_max: got %0d want 0", bus.max_abs_err);
    else n_pass++;
  endtask

  task automatic test_offset_wrap;
    int lat;
    mode = 1;
    sweep(50, lat);
    n_chk++;
    if (bus.err_cnt !== O_CNT) $display("FAIL off_cnt: got %0d want %0d", bus.err_cnt, O_CNT);
    else n_pass++;
    n_chk++;
    if (bus.sum_err !== O_SUM) $display("FAIL off_sum: got %0d want %0d", bus.sum_err, O_SUM);
    else n_pass++;
    n_chk++;
    if (bus.sum_sq_err !== O_SQ) $display("FAIL off_sq: got %0d want %0d", bus.sum_sq_err, O_SQ);
    else n_pass++;
    n_chk++;
    if (bus.max_abs_err !== O_MAX) $display("FAIL off_max: got %0d want %0d", bus.max_abs_err, O_MAX);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL done_pulse: done=%b busy=%b want 0,0", bus.done, bus.busy);
    else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (bus.err_cnt !== O_CNT || bus.sum_sq_err !== O_SQ)
      $display("FAIL hold_done: cnt=%0d sq=%0d want %0d %0d", bus.err_cnt, bus.sum_sq_err, O_CNT, O_SQ);
    else n_pass++;
  endtask

  task automatic test_zero;
    int lat;
    mode = 2;
    sweep(0, lat);
    n_chk++;
    if (bus.err_cnt !== Z_CNT) $display("FAIL zero_cnt: got %0d want %0d", bus.err_cnt, Z_CNT);
    else n_pass++;
    n_chk++;
    if (bus.sum_err !== Z_SUM) $display("FAIL zero_sum: got %h want %h", bus.sum_err, Z_SUM);
    else n_pass++;
    n_chk++;
    if (bus.sum_sq_err !== Z_SQ) $display("FAIL zero_sq: got %0d want %0d", bus.sum_sq_err, Z_SQ);
    else n_pass++;
    n_chk++;
    if (bus.max_abs_err !== Z_MAX) $display("FAIL zero_max: got %0d want %0d", bus.max_abs_err, Z_MAX);
    else n_pass++;
  endtask

  task automatic test_restart_in_done;
    int lat;
    mode = 1;
    sweep(0, lat);
    n_chk++;
    if ({bus.err_cnt, bus.sum_err, bus.sum_sq_err, bus.max_abs_err} !== {O_CNT, O_SUM, O_SQ, O_MAX})
      $display("FAIL restart_results: cnt=%0d sum=%0d sq=%0d max=%0d want %0d %0d %0d %0d",
               bus.err_cnt, bus.sum_err, bus.sum_sq_err, bus.max_abs_err, O_CNT, O_SUM, O_SQ, O_MAX);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int  lat;
    bit  seen;
    mode = 2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_chk++;
    if ({bus.mul_x, bus.mul_y, bus.busy, bus.done} !== 10'd0)
      $display("FAIL midrst_ctrl: x=%0d y=%0d busy=%b done=%b want 0",
               bus.mul_x, bus.mul_y, bus.busy, bus.done);
    else n_pass++;
    n_chk++;
    if ({bus.err_cnt, bus.sum_err, bus.sum_sq_err, bus.max_abs_err} !== '0)
      $display("FAIL midrst_results: cnt=%0d sum=%0d sq=%0d max=%0d want 0",
               bus.err_cnt, bus.sum_err, bus.sum_sq_err, bus.max_abs_err);
    else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < LAT + 50; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) $display("FAIL midrst_abort: got activity=%b want 0", seen);
    else n_pass++;
    sweep(0, lat);
    n_chk++;
    if ({bus.err_cnt, bus.sum_err, bus.sum_sq_err, bus.max_abs_err} !== {Z_CNT, Z_SUM, Z_SQ, Z_MAX})
      $display("FAIL midrst_rerun: cnt=%0d sum=%h sq=%0d max=%0d want %0d %h %0d %0d",
               bus.err_cnt, bus.sum_err, bus.sum_sq_err, bus.max_abs_err, Z_CNT, Z_SUM, Z_SQ, Z_MAX);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n_done;
    int t1;
    int t2;
    mode = 1;
    n_done = 0;
    t1 = -1;
    t2 = -1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 2 * LAT + 40; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        n_done++;
        if (n_done == 1) t1 = k;
        else t2 = k;
      end
      if (n_done == 2) begin
        bus.start = 1'b0;
        break;
      end
    end
    bus.start = 1'b0;
    n_chk++;
    if (t1 !== LAT) $display("FAIL b2b_first: got %0d want %0d", t1, LAT);
    else n_pass++;
    n_chk++;
    if (t2 !== 2 * LAT + 1) $display("FAIL b2b_second: got %0d want %0d", t2, 2 * LAT + 1);
    else n_pass++;
    n_chk++;
    if ({bus.err_cnt, bus.sum_err, bus.sum_sq_err, bus.max_abs_err} !== {O_CNT, O_SUM, O_SQ, O_MAX})
      $display("FAIL b2b_results: cnt=%0d sum=%0d sq=%0d max=%0d want %0d %0d %0d %0d",
               bus.err_cnt, bus.sum_err, bus.sum_sq_err, bus.max_abs_err, O_CNT, O_SUM, O_SQ, O_MAX);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_exact();
    test_offset_wrap();
    test_zero();
    test_restart_in_done();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
